// File: rtl/race_timer_if.sv
// rtl/race_timer_if.sv - race_timer control and status bundle
// Carries race control inputs and the per-car timing/status outputs.
interface race_timer_if #(
  parameter int NUM_CARS = 2,
  parameter int TIME_W   = 16
);
  logic                       start;
  logic                       stop;
  logic [NUM_CARS-1:0]        lap_finished;
  logic [NUM_CARS-1:0]        checkpoints_passed;
  logic [NUM_CARS*TIME_W-1:0] current_lap_time;
  logic [NUM_CARS*TIME_W-1:0] last_lap_time;
  logic [NUM_CARS*TIME_W-1:0] best_lap_time;
  logic [NUM_CARS*4-1:0]      lap_count;
  logic [NUM_CARS-1:0]        max_time_exceeded;
  logic [NUM_CARS-1:0]        car_finished;
  logic                       race_done;
  logic [2:0]                 winner;
  logic                       winner_valid;

  modport master (
    output start, stop, lap_finished, checkpoints_passed,
    input  current_lap_time, last_lap_time, best_lap_time, lap_count,
    input  max_time_exceeded, car_finished, race_done, winner, winner_valid
  );

  modport slave (
    input  start, stop, lap_finished, checkpoints_passed,
    output current_lap_time, last_lap_time, best_lap_time, lap_count,
    output max_time_exceeded, car_finished, race_done, winner, winner_valid
  );
endinterface

// File: rtl/race_timer.sv
// rtl/race_timer.sv - multi-car multi-lap race timer with shared timebase and winner detection
// Define RACE_TIMER_BCD_EN for packed-BCD time counting; default is plain binary.
module race_timer #(
  parameter int                NUM_CARS     = 2,
  parameter int                LAPS         = 3,
  parameter int                TICK_DIV     = 650000,
  parameter int                TIME_W       = 16,
  parameter logic [TIME_W-1:0] MAX_LAP_TIME = 16'h5999
) (
  input logic          pclk,
  input logic          rst,
  race_timer_if.slave  bus
);

  localparam int DIV_W = $clog2(TICK_DIV);

`ifdef RACE_TIMER_BCD_EN
  localparam logic [TIME_W-1:0] BEST_INIT = {(TIME_W/4){4'h9}};
`else
  localparam logic [TIME_W-1:0] BEST_INIT = '1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_PAUSED, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DIV_W-1:0]    r_div;
  logic [TIME_W-1:0]   r_cur  [NUM_CARS];
  logic [TIME_W-1:0]   r_last [NUM_CARS];
  logic [TIME_W-1:0]   r_best [NUM_CARS];
  logic [3:0]          r_cnt  [NUM_CARS];
  logic [NUM_CARS-1:0] r_fin;
  logic [NUM_CARS-1:0] r_ot;
  logic                r_done;
  logic [2:0]          r_win;
  logic                r_wv;

  logic                w_running;
  logic                w_tick;
  logic [NUM_CARS-1:0] w_active;
  logic [NUM_CARS-1:0] w_valid;
  logic [NUM_CARS-1:0] w_fin_set;
  logic [TIME_W-1:0]   w_inc [NUM_CARS];
  logic [2:0]          w_first;

  function automatic logic [TIME_W-1:0] f_inc(input logic [TIME_W-1:0] v);
`ifdef RACE_TIMER_BCD_EN
    logic [TIME_W-1:0] r;
    logic              c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < TIME_W/4; d++) begin
      if (c) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
`else
    return v + TIME_W'(1);
`endif
  endfunction

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (!bus.start) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_state_next = S_RUNNING;
        S_RUNNING: begin
          if (r_done)        w_state_next = S_DONE;
          else if (bus.stop) w_state_next = S_PAUSED;
        end
        S_PAUSED:  if (!bus.stop) w_state_next = S_RUNNING;
        S_DONE:    w_state_next = S_DONE;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  assign w_running = (r_state == S_RUNNING);
  assign w_tick    = w_running && (r_div == DIV_W'(TICK_DIV-1));

  always_ff @(posedge pclk or posedge rst) begin
    if (rst)                    r_div <= '0;
    else if (r_state == S_IDLE) r_div <= '0;
    else if (w_running)         r_div <= w_tick ? '0 : r_div + DIV_W'(1);
  end

  // A car stops timing once it has finished or gone overtime.
  always_comb begin
    w_active  = '0;
    w_valid   = '0;
    w_fin_set = '0;
    w_first   = 3'd0;
    for (int i = 0; i < NUM_CARS; i++) begin
      w_active[i]  = !r_fin[i] && !r_ot[i];
      w_valid[i]   = w_running && w_active[i] && bus.lap_finished[i] && bus.checkpoints_passed[i];
      w_fin_set[i] = w_valid[i] && (r_cnt[i] == 4'(LAPS-1));
      w_inc[i]     = f_inc(r_cur[i]);
    end
    for (int i = NUM_CARS-1; i >= 0; i--) begin
      if (w_fin_set[i]) w_first = 3'(i);
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CARS; i++) begin
        r_cur[i]  <= '0;
        r_last[i] <= '0;
        r_best[i] <= BEST_INIT;
        r_cnt[i]  <= 4'd0;
      end
      r_fin <= '0;
      r_ot  <= '0;
    end else if (r_state == S_IDLE) begin
      for (int i = 0; i < NUM_CARS; i++) begin
        r_cur[i] <= '0;
        r_cnt[i] <= 4'd0;
      end
      r_fin <= '0;
      r_ot  <= '0;
    end else begin
      for (int i = 0; i < NUM_CARS; i++) begin
        if (w_valid[i]) begin
          r_last[i] <= r_cur[i];
          if (r_cur[i] < r_best[i]) r_best[i] <= r_cur[i];
          r_cur[i] <= '0;
          r_cnt[i] <= r_cnt[i] + 4'd1;
          if (w_fin_set[i]) r_fin[i] <= 1'b1;
        end else if (w_tick && w_active[i]) begin
          if (w_inc[i] >= MAX_LAP_TIME) begin
            r_cur[i] <= MAX_LAP_TIME;
            r_ot[i]  <= 1'b1;
          end else begin
            r_cur[i] <= w_inc[i];
          end
        end
      end
    end
  end

  // Only the first finishing cycle names the winner; ties go to the lowest index.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_win  <= 3'd0;
      r_wv   <= 1'b0;
      r_done <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_win  <= 3'd0;
      r_wv   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (!r_wv && (|w_fin_set)) begin
        r_win <= w_first;
        r_wv  <= 1'b1;
      end
      r_done <= &(r_fin | r_ot);
    end
  end

  for (genvar g = 0; g < NUM_CARS; g++) begin : g_out
    assign bus.current_lap_time[g*TIME_W +: TIME_W] = r_cur[g];
    assign bus.last_lap_time[g*TIME_W +: TIME_W]    = r_last[g];
    assign bus.best_lap_time[g*TIME_W +: TIME_W]    = r_best[g];
    assign bus.lap_count[g*4 +: 4]                  = r_cnt[g];
  end

  assign bus.max_time_exceeded = r_ot;
  assign bus.car_finished      = r_fin;
  assign bus.race_done         = r_done;
  assign bus.winner            = r_win;
  assign bus.winner_valid      = r_wv;

endmodule

// File: tb/tb_race_timer.sv
// tb/tb_race_timer.sv - randomized scoreboard bench for race_timer
// Integer-time reference model; expected snapshots queued per cycle, checked by a monitor.
module tb_race_timer;
  localparam int              NC   = 2;
  localparam int              LAPS = 2;
  localparam int              TD   = 4;
  localparam int              TW   = 16;
  localparam logic [TW-1:0]   MAXT = 16'h0015;
`ifdef RACE_TIMER_BCD_EN
  localparam bit BCD = 1'b1;
`else
  localparam bit BCD = 1'b0;
`endif
  localparam int NO_BEST = 1 << 30;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct {
    logic [NC*TW-1:0] cur;
    logic [NC*TW-1:0] last;
    logic [NC*TW-1:0] best;
    logic [NC*4-1:0]  cnt;
    logic [NC-1:0]    ot;
    logic [NC-1:0]    fin;
    logic             done;
    logic [2:0]       win;
    logic             wv;
  } exp_t;

  logic pclk;
  logic rst;
  int   n_vec;
  int   n_err;
  exp_t q[$];

  race_timer_if #(.NUM_CARS(NC), .TIME_W(TW)) rif ();

  race_timer #(
    .NUM_CARS(NC), .LAPS(LAPS), .TICK_DIV(TD), .TIME_W(TW), .MAX_LAP_TIME(MAXT)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (rif.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int m_st, m_div, m_win, max_u;
  int m_cur[NC], m_last[NC], m_best[NC], m_cnt[NC];
  bit m_ot[NC], m_fin[NC];
  bit m_done, m_wv;

  function automatic int dec(input logic [TW-1:0] v);
    int s, w;
    if (!BCD) return int'(v);
    s = 0;
    w = 1;
    for (int k = 0; k < TW/4; k++) begin
      s += int'(v[k*4 +: 4]) * w;
      w *= 10;
    end
    return s;
  endfunction

  function automatic logic [TW-1:0] enc(input int u);
    logic [TW-1:0] r;
    int x;
    if (u == NO_BEST) begin
      r = '1;
      if (BCD) r = {(TW/4){4'h9}};
      return r;
    end
    if (!BCD) return TW'(u);
    r = '0;
    x = u;
    for (int k = 0; k < TW/4; k++) begin
      r[k*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_div = 0; m_win = 0; m_done = 0; m_wv = 0;
    for (int i = 0; i < NC; i++) begin
      m_cur[i] = 0; m_last[i] = 0; m_best[i] = NO_BEST; m_cnt[i] = 0;
      m_ot[i] = 0; m_fin[i] = 0;
    end
  endtask

  task automatic model_step(input bit st, input bit sp, input logic [NC-1:0] lf,
                            input logic [NC-1:0] cp);
    bit tick, all_old, any_new, act;
    int first;
    tick    = (m_st == M_RUN) && (m_div == TD-1);
    all_old = 1;
    for (int i = 0; i < NC; i++) if (!(m_fin[i] || m_ot[i])) all_old = 0;
    any_new = 0;
    first   = 0;
    if (m_st == M_IDLE) begin
      for (int i = 0; i < NC; i++) begin
        m_cur[i] = 0; m_cnt[i] = 0; m_ot[i] = 0; m_fin[i] = 0;
      end
      m_wv = 0; m_win = 0; m_done = 0; m_div = 0;
    end else begin
      for (int i = NC-1; i >= 0; i--) begin
        act = !m_fin[i] && !m_ot[i];
        if (m_st == M_RUN && act && lf[i] && cp[i]) begin
          m_last[i] = m_cur[i];
          if (m_cur[i] < m_best[i]) m_best[i] = m_cur[i];
          m_cur[i] = 0;
          m_cnt[i]++;
          if (m_cnt[i] == LAPS) begin
            m_fin[i] = 1; any_new = 1; first = i;
          end
        end else if (tick && act) begin
          m_cur[i]++;
          if (m_cur[i] >= max_u) begin
            m_cur[i] = max_u; m_ot[i] = 1;
          end
        end
      end
      if (any_new && !m_wv) begin
        m_wv = 1; m_win = first;
      end
      m_done = all_old;
      if (m_st == M_RUN) m_div = (m_div == TD-1) ? 0 : m_div + 1;
    end
    if (!st) m_st = M_IDLE;
    else if (m_st == M_IDLE) m_st = M_RUN;
    else if (m_st == M_RUN) begin
      if (all_old) m_st = M_DONE;
      else if (sp) m_st = M_PAUSE;
    end else if (m_st == M_PAUSE && !sp) m_st = M_RUN;
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.cur = '0; e.last = '0; e.best = '0; e.cnt = '0; e.ot = '0; e.fin = '0;
    for (int i = 0; i < NC; i++) begin
      e.cur[i*TW +: TW]  = enc(m_cur[i]);
      e.last[i*TW +: TW] = enc(m_last[i]);
      e.best[i*TW +: TW] = enc(m_best[i]);
      e.cnt[i*4 +: 4]    = 4'(m_cnt[i]);
      e.ot[i]            = m_ot[i];
      e.fin[i]           = m_fin[i];
    end
    e.done = m_done;
    e.win  = 3'(m_win);
    e.wv   = m_wv;
    return e;
  endfunction

  task automatic drive(input bit r, input bit st, input bit sp, input logic [NC-1:0] lf,
                       input logic [NC-1:0] cp);
    @(negedge pclk);
    rst                    = r;
    rif.start              = st;
    rif.stop               = sp;
    rif.lap_finished       = lf;
    rif.checkpoints_passed = cp;
    if (r) model_reset();
    else   model_step(st, sp, lf, cp);
    q.push_back(snap());
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge pclk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("current_lap_time",  32'(rif.current_lap_time),  32'(e.cur));
        check("last_lap_time",     32'(rif.last_lap_time),     32'(e.last));
        check("best_lap_time",     32'(rif.best_lap_time),     32'(e.best));
        check("lap_count",         32'(rif.lap_count),         32'(e.cnt));
        check("max_time_exceeded", 32'(rif.max_time_exceeded), 32'(e.ot));
        check("car_finished",      32'(rif.car_finished),      32'(e.fin));
        check("race_done",         32'(rif.race_done),         32'(e.done));
        check("winner",            32'(rif.winner),            32'(e.win));
        check("winner_valid",      32'(rif.winner_valid),      32'(e.wv));
      end
    end
  end

  initial begin
    int           lfdiv;
    bit           sp;
    logic [NC-1:0] lf, cp;
    int           lfdivs[6];
    n_vec = 0;
    n_err = 0;
    max_u = dec(MAXT);
    lfdivs = '{8, 40, 12, 10, 0, 20};
    rst = 1'b1;
    rif.start = 1'b0;
    rif.stop = 1'b0;
    rif.lap_finished = '0;
    rif.checkpoints_passed = '0;
    model_reset();
    repeat (3) drive(1'b1, 1'b0, 1'b0, '0, '0);
    for (int run = 0; run < 6; run++) begin
      lfdiv = lfdivs[run];
      sp = 1'b0;
      for (int c = 0; c < 200; c++) begin
        lf = '0;
        cp = '0;
        for (int i = 0; i < NC; i++) begin
          lf[i] = (lfdiv != 0) && (($urandom % lfdiv) == 0);
          cp[i] = ($urandom % 5) != 0;
        end
        if ((lf != '0) && (($urandom % 4) == 0)) begin
          lf = '1;
          cp = '1;
        end
        if (run == 0) begin
          if (c == 30)  sp = 1'b1;
          if (c == 130) sp = 1'b0;
        end else if (($urandom % 50) == 0) begin
          sp = !sp;
        end
        if (run == 3 && c == 60) drive(1'b1, 1'b1, sp, lf, cp);
        else                     drive(1'b0, 1'b1, sp, lf, cp);
      end
      repeat (3) drive(1'b0, 1'b0, 1'b0, '0, '0);
    end
    repeat (3) @(posedge pclk);
    #3;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
